// File: rtl/clkdiv_ratio_ctrl.sv
// Purpose : run-time ratio controller for the block divider; emits a registered
//           divided clock (/2,/4,/8,/16) and a one-cycle tick per high phase.
// Latency : outputs are flops; en/request effects appear one clk after sampling.
// Backpressure: req_ready drops after a transfer and returns once the new
//           ratio is in force; req_valid must hold while req_ready is low.
//
// Ports:
//   clk, rst_n         core clock, asynchronous active-low reset
//   en                 run enable (level); stop is applied at a period end
//   req_valid/req_div  ratio-change request (0:/2 1:/4 2:/8 3:/16)
//   req_ready          controller can take a request this cycle
//   cur_div            ratio code currently applied
//   div_clk            divided clock, straight from a flop
//   tick               first cycle of every div_clk high phase
//   switching          a real ratio change is in flight (drain or gap)
module clkdiv_ratio_ctrl #(
    parameter logic [1:0] RESET_DIV  = 2'd0,
    parameter int         GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       req_valid,
    input  logic [1:0] req_div,
    output logic       req_ready,
    output logic [1:0] cur_div,
    output logic       div_clk,
    output logic       tick,
    output logic       switching
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam bit         HAS_GAP  = (GAP_CYCLES != 0);
    localparam logic [2:0] GAP_LAST = (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;

    logic [1:0] state;
    logic [1:0] nxt_state;
    logic [3:0] cnt;
    logic [3:0] nxt_cnt;
    logic [2:0] gap_cnt;
    logic [2:0] nxt_gap_cnt;
    logic [1:0] nxt_cur_div;
    logic [1:0] pend_div;
    logic [1:0] nxt_pend_div;
    logic       pend;
    logic       nxt_pend;
    logic       nxt_req_ready;
    logic       nxt_switching;

    logic       accept;
    logic       acc_chg;
    logic       pend_eff;
    logic       stop_eff;
    logic [1:0] div_eff;
    logic [3:0] last_cnt;
    logic       at_last;
    logic       nxt_active;
    logic [3:0] nxt_half;

    assign accept   = req_valid && req_ready;
    // A request for the ratio already in force is a no-op transfer.
    assign acc_chg  = accept && (req_div != cur_div);
    // N-1 for N = 2^(cur_div+1): 1, 3, 7, 15.
    assign last_cnt = {cur_div == 2'd3, cur_div >= 2'd2, cur_div >= 2'd1, 1'b1};
    assign at_last  = (cnt == last_cnt);

    always_comb begin
        nxt_state     = state;
        nxt_cnt       = cnt;
        nxt_gap_cnt   = gap_cnt;
        nxt_cur_div   = cur_div;
        nxt_pend      = pend;
        nxt_pend_div  = pend_div;
        nxt_req_ready = req_ready;
        nxt_switching = switching;

        // A change accepted on this very edge counts as pending, so a request
        // landing on the last cycle of a period is applied at that boundary.
        pend_eff = pend || acc_chg;
        div_eff  = pend ? pend_div : req_div;
        // In RUN a low en starts a stop-drain; a DRAIN without a pending
        // change is by construction a stop-drain and ignores en rising again.
        stop_eff = (state == ST_RUN) ? !en : !pend;

        // Handshake bookkeeping shared by every state. Transfers that do not
        // leave a change pending (IDLE or same-ratio) free req_ready again
        // one cycle later.
        if (accept) begin
            nxt_req_ready = 1'b0;
            nxt_switching = acc_chg;
        end else if (!req_ready && !pend) begin
            nxt_req_ready = 1'b1;
            nxt_switching = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                // Nothing is toggling, so the new ratio applies at once.
                if (accept) begin
                    nxt_cur_div = req_div;
                end
                if (en) begin
                    nxt_state = ST_RUN;
                    nxt_cnt   = 4'd0;
                end
            end

            ST_RUN, ST_DRAIN: begin
                if (acc_chg) begin
                    nxt_pend     = 1'b1;
                    nxt_pend_div = req_div;
                end
                if (at_last && (pend_eff || stop_eff)) begin
                    // Period boundary: the old period has been emitted in full.
                    nxt_cnt = 4'd0;
                    if (pend_eff) begin
                        nxt_cur_div = div_eff;
                        if (HAS_GAP) begin
                            nxt_state   = ST_GAP;
                            nxt_gap_cnt = 3'd0;
                        end else begin
                            nxt_pend      = 1'b0;
                            nxt_req_ready = 1'b1;
                            nxt_switching = 1'b0;
                            nxt_state     = en ? ST_RUN : ST_IDLE;
                        end
                    end else begin
                        nxt_state = ST_IDLE;
                    end
                end else begin
                    nxt_cnt   = at_last ? 4'd0 : cnt + 4'd1;
                    nxt_state = (pend_eff || stop_eff) ? ST_DRAIN : ST_RUN;
                end
            end

            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    nxt_pend      = 1'b0;
                    nxt_req_ready = 1'b1;
                    nxt_switching = 1'b0;
                    nxt_cnt       = 4'd0;
                    nxt_state     = en ? ST_RUN : ST_IDLE;
                end else begin
                    nxt_gap_cnt = gap_cnt + 3'd1;
                end
            end

            default: begin
                nxt_state = ST_IDLE;
            end
        endcase

        // div_clk/tick are derived from the next count so that they are
        // registered alongside it and never glitch.
        nxt_active = (nxt_state == ST_RUN) || (nxt_state == ST_DRAIN);
        nxt_half   = 4'b0001 << nxt_cur_div;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            gap_cnt   <= 3'd0;
            cur_div   <= RESET_DIV;
            pend_div  <= RESET_DIV;
            pend      <= 1'b0;
            req_ready <= 1'b1;
            switching <= 1'b0;
            div_clk   <= 1'b0;
            tick      <= 1'b0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            gap_cnt   <= nxt_gap_cnt;
            cur_div   <= nxt_cur_div;
            pend_div  <= nxt_pend_div;
            pend      <= nxt_pend;
            req_ready <= nxt_req_ready;
            switching <= nxt_switching;
            div_clk   <= nxt_active && (nxt_cnt < nxt_half);
            tick      <= nxt_active && (nxt_cnt == 4'd0);
        end
    end

endmodule

// File: tb/tb_clkdiv_ratio_ctrl.sv
module tb_clkdiv_ratio_ctrl;

    localparam logic [1:0] RESET_DIV  = 2'd0;
    localparam int         GAP_CYCLES = 2;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       en        = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_div   = 2'd0;
    logic       req_ready;
    logic [1:0] cur_div;
    logic       div_clk;
    logic       tick;
    logic       switching;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clkdiv_ratio_ctrl #(
        .RESET_DIV (RESET_DIV),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req_valid(req_valid),
        .req_div  (req_div),
        .req_ready(req_ready),
        .cur_div  (cur_div),
        .div_clk  (div_clk),
        .tick     (tick),
        .switching(switching)
    );

    // Reference model: whole periods are scheduled as a queue of per-cycle
    // {div_clk,tick} values; decisions are taken only when a period (or gap)
    // has been fully emitted.
    logic [1:0] mq[$];
    int         m_phase;   // 0 idle, 1 period, 2 gap
    logic [1:0] m_cur;
    logic [1:0] m_pdiv;
    logic       m_pend;
    logic       m_ready;
    logic       m_sw;
    logic       m_stop;

    function automatic void m_reset();
        mq.delete();
        m_phase = 0;
        m_cur   = RESET_DIV;
        m_pdiv  = RESET_DIV;
        m_pend  = 1'b0;
        m_ready = 1'b1;
        m_sw    = 1'b0;
        m_stop  = 1'b0;
    endfunction

    function automatic void m_start();
        int n = 2 << m_cur;
        for (int k = 0; k < n; k++) mq.push_back({k < n / 2, k == 0});
        m_phase = 1;
        m_stop  = 1'b0;
    endfunction

    function automatic void m_finish_change(input logic en_s);
        m_pend  = 1'b0;
        m_ready = 1'b1;
        m_sw    = 1'b0;
        if (en_s) m_start();
        else m_phase = 0;
    endfunction

    function automatic void m_edge(input logic en_s, input logic vld_s, input logic [1:0] div_s);
        if (vld_s && m_ready) begin
            m_ready = 1'b0;
            if (m_phase == 0) begin
                m_sw  = (div_s != m_cur);
                m_cur = div_s;
            end else if (div_s != m_cur) begin
                m_pend = 1'b1;
                m_pdiv = div_s;
                m_sw   = 1'b1;
            end
        end else if (!m_ready && !m_pend) begin
            m_ready = 1'b1;
            m_sw    = 1'b0;
        end
        case (m_phase)
            0: if (en_s) m_start();
            1: begin
                if (!en_s) m_stop = 1'b1;
                void'(mq.pop_front());
                if (mq.size() == 0) begin
                    if (m_pend) begin
                        m_cur = m_pdiv;
                        if (GAP_CYCLES > 0) begin
                            m_phase = 2;
                            for (int k = 0; k < GAP_CYCLES; k++) mq.push_back(2'b00);
                        end else begin
                            m_finish_change(en_s);
                        end
                    end else if (m_stop) begin
                        m_phase = 0;
                    end else begin
                        m_start();
                    end
                end
            end
            default: begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_finish_change(en_s);
            end
        endcase
    endfunction

    function automatic logic [5:0] m_vec();
        logic [1:0] dt;
        dt = (mq.size() > 0) ? mq[0] : 2'b00;
        return {dt, m_cur, m_ready, m_sw};
    endfunction

    function automatic logic [5:0] obs();
        return {div_clk, tick, cur_div, req_ready, switching};
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst_n) m_reset();
        else m_edge(en, req_valid, req_div);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        m_reset();
        checks++; if (div_clk !== 1'b0) begin errors++; $display("FAIL reset_div_clk got %b want 0", div_clk); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
        checks++; if (cur_div !== RESET_DIV) begin errors++; $display("FAIL reset_cur_div got %0d want %0d", cur_div, RESET_DIV); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if (switching !== 1'b0) begin errors++; $display("FAIL reset_switching got %b want 0", switching); end
        rst_n = 1'b1;
    endtask

    task automatic test_start();
        en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            checks++;
            if (obs() !== m_vec()) begin errors++; $display("FAIL start_model cyc %0d got %b want %b", i, obs(), m_vec()); end
            checks++;
            if (div_clk !== (i % 2 == 1) || tick !== (i % 2 == 1) || cur_div !== 2'd0 || req_ready !== 1'b1) begin
                errors++; $display("FAIL start_div2 cyc %0d got div %b tick %b cur %0d rdy %b", i, div_clk, tick, cur_div, req_ready);
            end
        end
    endtask

    task automatic test_switch();
        logic hs;
        logic done = 1'b0;
        req_valid = 1'b1;
        req_div   = 2'd1;
        for (int i = 0; i < 20 && req_valid; i++) begin
            hs = req_valid && req_ready;
            step();
            checks++; if (obs() !== m_vec()) begin errors++; $display("FAIL sw_req1 cyc %0d got %b want %b", i, obs(), m_vec()); end
            if (hs) req_valid = 1'b0;
        end
        for (int i = 0; i < 40 && !done; i++) begin
            if (req_ready && tick) done = 1'b1;
            else begin
                step();
                checks++; if (obs() !== m_vec()) begin errors++; $display("FAIL sw_wait cyc %0d got %b want %b", i, obs(), m_vec()); end
            end
        end
        checks++; if (!done || cur_div !== 2'd1) begin errors++; $display("FAIL sw_to_div4 got done %b cur %0d want done 1 cur 1", done, cur_div); end
        step();
        req_valid = 1'b1;
        req_div   = 2'd2;
        step();
        req_valid = 1'b0;
        for (int s = 0; s < 12; s++) begin
            checks++; if (obs() !== m_vec()) begin errors++; $display("FAIL sw_model s %0d got %b want %b", s, obs(), m_vec()); end
            checks++;
            if (div_clk !== (s >= 4 && s < 8) || tick !== (s == 4) || cur_div !== ((s >= 2) ? 2'd2 : 2'd1) ||
                req_ready !== (s >= 4) || switching !== (s < 4)) begin
                errors++; $display("FAIL sw_seq s %0d got div %b tick %b cur %0d rdy %b sw %b", s, div_clk, tick, cur_div, req_ready, switching);
            end
            step();
        end
    endtask

    task automatic test_stop();
        for (int i = 0; i < 20 && !tick; i++) begin
            step();
            checks++; if (obs() !== m_vec()) begin errors++; $display("FAIL stop_wait cyc %0d got %b want %b", i, obs(), m_vec()); end
        end
        step();
        step();
        en = 1'b0;
        step();
        for (int s = 0; s < 10; s++) begin
            checks++; if (obs() !== m_vec()) begin errors++; $display("FAIL stop_model s %0d got %b want %b", s, obs(), m_vec()); end
            checks++;
            if (div_clk !== (s == 0) || tick !== 1'b0 || cur_div !== 2'd2) begin
                errors++; $display("FAIL stop_seq s %0d got div %b tick %b cur %0d", s, div_clk, tick, cur_div);
            end
            step();
        end
    endtask

    task automatic test_same_ratio();
        req_valid = 1'b1;
        req_div   = 2'd1;
        step();
        req_valid = 1'b0;
        checks++; if (obs() !== m_vec() || cur_div !== 2'd1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL idle_req got %b want %b", obs(), m_vec()); end
        step();
        checks++; if (obs() !== m_vec() || req_ready !== 1'b1) begin
            errors++; $display("FAIL idle_req_ready got %b want %b", obs(), m_vec()); end
        en = 1'b1;
        for (int i = 0; i < 10 && !tick; i++) begin
            step();
            checks++; if (obs() !== m_vec()) begin errors++; $display("FAIL same_wait cyc %0d got %b want %b", i, obs(), m_vec()); end
        end
        step();
        req_valid = 1'b1;
        req_div   = 2'd1;
        step();
        req_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            checks++; if (obs() !== m_vec()) begin errors++; $display("FAIL same_model s %0d got %b want %b", s, obs(), m_vec()); end
            checks++;
            if (div_clk !== (s >= 2) || tick !== (s == 2) || req_ready !== (s != 0) || switching !== 1'b0) begin
                errors++; $display("FAIL same_seq s %0d got div %b tick %b rdy %b sw %b", s, div_clk, tick, req_ready, switching);
            end
            step();
        end
    endtask

    task automatic test_hold_request();
        logic hs;
        int   accepts = 0;
        int   period  = 0;
        logic done    = 1'b0;
        req_valid = 1'b1;
        req_div   = 2'd2;
        for (int i = 0; i < 100 && accepts < 2; i++) begin
            hs = req_valid && req_ready;
            step();
            checks++; if (obs() !== m_vec()) begin errors++; $display("FAIL hold_model cyc %0d got %b want %b", i, obs(), m_vec()); end
            if (hs) begin
                accepts++;
                if (accepts == 1) req_div = 2'd3;
                else req_valid = 1'b0;
            end
        end
        checks++; if (accepts != 2) begin errors++; $display("FAIL hold_accepts got %0d want 2", accepts); end
        req_valid = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (tick && req_ready && cur_div == 2'd3) done = 1'b1;
            else begin
                step();
                checks++; if (obs() !== m_vec()) begin errors++; $display("FAIL hold_wait cyc %0d got %b want %b", i, obs(), m_vec()); end
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL hold_apply got cur %0d want 3", cur_div); end
        for (int i = 0; i < 40 && (period == 0 || !tick); i++) begin
            step();
            period++;
            checks++; if (obs() !== m_vec()) begin errors++; $display("FAIL hold_period cyc %0d got %b want %b", i, obs(), m_vec()); end
        end
        checks++; if (period != 16 || cur_div !== 2'd3) begin
            errors++; $display("FAIL hold_div16 got period %0d cur %0d want 16 cur 3", period, cur_div); end
    endtask

    task automatic test_reset_gap();
        logic hs;
        logic in_gap = 1'b0;
        req_valid = 1'b1;
        req_div   = 2'd2;
        for (int i = 0; i < 60 && !in_gap; i++) begin
            hs = req_valid && req_ready;
            step();
            checks++; if (obs() !== m_vec()) begin errors++; $display("FAIL rgap_wait cyc %0d got %b want %b", i, obs(), m_vec()); end
            if (hs) req_valid = 1'b0;
            if (cur_div == 2'd2 && switching && !div_clk) in_gap = 1'b1;
        end
        checks++; if (!in_gap) begin errors++; $display("FAIL rgap_reach got cur %0d sw %b want cur 2 sw 1", cur_div, switching); end
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        checks++; if (obs() !== {2'b00, RESET_DIV, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rgap_async got %b want %b", obs(), {2'b00, RESET_DIV, 1'b1, 1'b0}); end
        step();
        #2;
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (obs() !== m_vec() || div_clk !== (i % 2 == 1) || cur_div !== RESET_DIV) begin
                errors++; $display("FAIL rgap_restart cyc %0d got %b want %b", i, obs(), m_vec());
            end
        end
    endtask

    task automatic test_random();
        logic hs;
        for (int i = 0; i < 4000; i++) begin
            hs = req_valid && req_ready;
            step();
            checks++; if (obs() !== m_vec()) begin errors++; $display("FAIL random cyc %0d got %b want %b", i, obs(), m_vec()); end
            if ($urandom_range(0, 39) == 0) en = ~en;
            if (!(req_valid && !hs)) begin
                req_valid = ($urandom_range(0, 7) == 0);
                req_div   = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                #1;
                m_reset();
                checks++; if (obs() !== {2'b00, RESET_DIV, 1'b1, 1'b0}) begin
                    errors++; $display("FAIL random_reset cyc %0d got %b want %b", i, obs(), {2'b00, RESET_DIV, 1'b1, 1'b0}); end
                #1;
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_start();
        test_switch();
        test_stop();
        test_same_ratio();
        test_hold_request();
        test_reset_gap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
